// File: rtl/fifo_ctrl.sv
// rtl/fifo_ctrl.sv - synchronous FIFO controller driving a dual-port FIFO RAM
module fifo_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int AF_LEVEL   = 2**ADDR_WIDTH - 4,
    parameter int AE_LEVEL   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow,
    input  logic                  err_clr,
    output logic [ADDR_WIDTH-1:0] ram_addr_0,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    output logic                  ram_cs_0,
    output logic                  ram_we_0,
    output logic                  ram_oe_0,
    output logic [ADDR_WIDTH-1:0] ram_addr_1,
    output logic                  ram_cs_1,
    output logic                  ram_oe_1,
    output logic                  ram_we_1,
    input  logic [DATA_WIDTH-1:0] ram_rdata
);

    localparam int CW = ADDR_WIDTH + 1;
    localparam logic [ADDR_WIDTH:0] FULL_COUNT = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] AF_COUNT   = CW'(AF_LEVEL);
    localparam logic [ADDR_WIDTH:0] AE_COUNT   = CW'(AE_LEVEL);

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic                  wr_accept;
    logic                  rd_accept;

    // Flags come only from the registered count; pointer equality is ambiguous on wrap.
    assign full         = (count == FULL_COUNT);
    assign empty        = (count == '0);
    assign almost_full  = (count >= AF_COUNT);
    assign almost_empty = (count <= AE_COUNT);

    // Reset gating keeps the RAM write strobe low the instant rst rises,
    // even if wr_en is still held by the upstream logic.
    assign wr_accept = wr_en & ~full & ~rst;
    assign rd_accept = rd_en & ~empty & ~rst;

    // Port 0 is write-only, port 1 is permanently enabled for reading.
    assign ram_addr_0 = wr_ptr;
    assign ram_wdata  = wr_data;
    assign ram_cs_0   = wr_accept;
    assign ram_we_0   = wr_accept;
    assign ram_oe_0   = 1'b0;
    assign ram_addr_1 = rd_ptr;
    assign ram_cs_1   = 1'b1;
    assign ram_oe_1   = 1'b1;
    assign ram_we_1   = 1'b0;

    // Pointer advance; natural binary wrap at 2**ADDR_WIDTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_accept) wr_ptr <= wr_ptr + 1'b1;
            if (rd_accept) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Occupancy: unchanged when both or neither side is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else begin
            case ({wr_accept, rd_accept})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Registered read word: captured from the RAM one clock after the accepted read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_accept;
            if (rd_accept) rd_data <= ram_rdata;
        end
    end

    // Sticky errors; a fresh error in the clear cycle takes priority over err_clr.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_en && full)  overflow <= 1'b1;
            else if (err_clr)   overflow <= 1'b0;
            if (rd_en && empty) underflow <= 1'b1;
            else if (err_clr)   underflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fifo_ctrl.sv
// tb/tb_fifo_ctrl.sv - table-driven self-checking bench for fifo_ctrl
module tb_fifo_ctrl;

    localparam int DW = 8;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_en = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          rd_en = 1'b0;
    logic          err_clr = 1'b0;
    logic [DW-1:0] rd_data;
    logic          rd_valid, full, empty, almost_full, almost_empty;
    logic [AW:0]   count;
    logic          overflow, underflow;
    logic [AW-1:0] ram_addr_0, ram_addr_1;
    logic [DW-1:0] ram_wdata, ram_rdata;
    logic          ram_cs_0, ram_we_0, ram_oe_0, ram_cs_1, ram_oe_1, ram_we_1;

    int checks = 0;
    int errors = 0;

    fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AF_LEVEL(4), .AE_LEVEL(4)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .rd_data(rd_data), .rd_valid(rd_valid), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
        .overflow(overflow), .underflow(underflow), .err_clr(err_clr),
        .ram_addr_0(ram_addr_0), .ram_wdata(ram_wdata), .ram_cs_0(ram_cs_0),
        .ram_we_0(ram_we_0), .ram_oe_0(ram_oe_0), .ram_addr_1(ram_addr_1),
        .ram_cs_1(ram_cs_1), .ram_oe_1(ram_oe_1), .ram_we_1(ram_we_1),
        .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    // Behavioural dual-port RAM: synchronous write on port 0, combinational read on port 1.
    logic [DW-1:0] mem [2**AW];
    always @(posedge clk) if (ram_cs_0 && ram_we_0) mem[ram_addr_0] <= ram_wdata;
    assign ram_rdata = mem[ram_addr_1];

    typedef struct {
        logic wr; logic rd; logic clr; int wd;
        int cnt; logic rv; int rdd; logic ovf; logic unf;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic wr, input logic rd, input logic clr, input int wd,
                                input int cnt, input logic rv, input int rdd,
                                input logic ovf, input logic unf);
        vec_t v;
        v.wr = wr; v.rd = rd; v.clr = clr; v.wd = wd;
        v.cnt = cnt; v.rv = rv; v.rdd = rdd; v.ovf = ovf; v.unf = unf;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] observed();
        return {13'd0, count, empty, full, almost_empty, almost_full,
                rd_valid, rd_data, overflow, underflow};
    endfunction

    function automatic logic [31:0] expected(input int cnt, input logic rv, input int rdd,
                                             input logic ovf, input logic unf);
        logic [3:0] c;
        logic [7:0] d;
        c = 4'(cnt);
        d = 8'(rdd);
        return {13'd0, c, (cnt == 0), (cnt == 8), (cnt <= 4), (cnt >= 4), rv, d, ovf, unf};
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset then idle three cycles.
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) cycle();
        chk("reset_state", observed(), expected(0, 0, 0, 0, 0));
        chk("reset_we0", {31'd0, ram_we_0}, 32'd0);
        chk("ram_consts", {28'd0, ram_oe_0, ram_cs_1, ram_oe_1, ram_we_1}, 32'b0110);

        // Write three / read three.
        tbl.push_back(mk(1, 0, 0, 'h11, 1, 0, 'h00, 0, 0));
        tbl.push_back(mk(1, 0, 0, 'h22, 2, 0, 'h00, 0, 0));
        tbl.push_back(mk(1, 0, 0, 'h33, 3, 0, 'h00, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0,    2, 1, 'h11, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0,    1, 1, 'h22, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0,    0, 1, 'h33, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0,    0, 0, 'h33, 0, 0));
        // Fill to full, overflow, clear, simultaneous access when full.
        for (int i = 0; i < 8; i++) tbl.push_back(mk(1, 0, 0, 'hA0 + i, i + 1, 0, 'h33, 0, 0));
        tbl.push_back(mk(1, 0, 0, 'hEE, 8, 0, 'h33, 1, 0));
        tbl.push_back(mk(0, 0, 1, 0,    8, 0, 'h33, 0, 0));
        tbl.push_back(mk(1, 1, 0, 'h55, 7, 1, 'hA0, 1, 0));
        tbl.push_back(mk(0, 0, 1, 0,    7, 0, 'hA0, 0, 0));
        for (int i = 1; i < 8; i++) tbl.push_back(mk(0, 1, 0, 0, 7 - i, 1, 'hA0 + i, 0, 0));
        // Simultaneous access when empty, then clear/error priority.
        tbl.push_back(mk(1, 1, 0, 'h66, 1, 0, 'hA7, 0, 1));
        tbl.push_back(mk(0, 1, 1, 0,    0, 1, 'h66, 0, 0));
        tbl.push_back(mk(0, 1, 1, 0,    0, 0, 'h66, 0, 1));
        tbl.push_back(mk(0, 0, 1, 0,    0, 0, 'h66, 0, 0));

        foreach (tbl[i]) begin
            wr_en   = tbl[i].wr;
            rd_en   = tbl[i].rd;
            err_clr = tbl[i].clr;
            wr_data = 8'(tbl[i].wd);
            cycle();
            chk($sformatf("vec%0d", i), observed(),
                expected(tbl[i].cnt, tbl[i].rv, tbl[i].rdd, tbl[i].ovf, tbl[i].unf));
        end
        wr_en = 0; rd_en = 0; err_clr = 0;

        // Asynchronous reset in mid-cycle with five words held and wr_en still high.
        for (int i = 0; i < 5; i++) begin
            wr_en = 1; wr_data = 8'(8'hC0 + i);
            cycle();
        end
        chk("pre_reset_count", {28'd0, count}, 32'd5);
        #2 rst = 1'b1;
        #1;
        chk("async_reset_state", observed(), expected(0, 0, 0, 0, 0));
        chk("async_reset_strobe", {29'd0, ram_cs_0, ram_we_0, |ram_addr_0}, 32'd0);
        cycle();
        wr_en = 0;
        #1 rst = 1'b0;
        cycle();

        // err_clr with a concurrent read while empty: the new error wins.
        rd_en = 1; err_clr = 1;
        cycle();
        chk("clr_vs_underflow", {31'd0, underflow}, 32'd1);
        rd_en = 0; err_clr = 1;
        cycle();
        chk("underflow_cleared", {31'd0, underflow}, 32'd0);
        err_clr = 0;

        // Pointer wrap: write 6 / read 6, then write 5 / read 5 across 7 -> 0.
        for (int i = 0; i < 6; i++) begin
            wr_en = 1; wr_data = 8'(8'hB0 + i);
            #1 chk($sformatf("wrapA_waddr%0d", i), {28'd0, ram_we_0, ram_addr_0}, 32'(8 + i));
            cycle();
        end
        wr_en = 0;
        for (int i = 0; i < 6; i++) begin
            rd_en = 1;
            cycle();
            chk($sformatf("wrapA_rd%0d", i), {23'd0, rd_valid, rd_data}, 32'(9'h100 + 8'hB0 + i));
        end
        rd_en = 0;
        for (int i = 0; i < 5; i++) begin
            wr_en = 1; wr_data = 8'(8'hD0 + i);
            #1 chk($sformatf("wrapB_waddr%0d", i), {29'd0, ram_addr_0}, 32'((6 + i) % 8));
            cycle();
        end
        wr_en = 0;
        #1 chk("wrapB_waddr_end", {29'd0, ram_addr_0}, 32'd3);
        for (int i = 0; i < 5; i++) begin
            rd_en = 1;
            #1 chk($sformatf("wrapB_raddr%0d", i), {29'd0, ram_addr_1}, 32'((6 + i) % 8));
            cycle();
            chk($sformatf("wrapB_rd%0d", i), {23'd0, rd_valid, rd_data}, 32'(9'h100 + 8'hD0 + i));
        end
        rd_en = 0;
        cycle();
        chk("final_state", observed(), expected(0, 0, 'hD4, 0, 0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
